// File: rtl/hall_meas_pkg.sv
// Shared constants for the Hall half-period meter.
// State encodings, count width and the default stall limit.
package hall_meas_pkg;

    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] TIMEOUT_DEF = 16'hFFFF;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

endpackage

// File: rtl/hall_period_meter_edge_sync.sv
// Synchronizes an asynchronous level and flags both edges.
// E is high for one cycle whenever the synced level changes.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic IN_SIG,
    output logic level,
    output logic E
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], IN_SIG};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign E     = level ^ hist_q;

endmodule

// File: rtl/hall_period_meter.sv
// Half-period meter: counts CLK cycles between edges of IN_SIG.
// Define HALL_PERIOD_AVG_EN to average consecutive half-periods.
module hall_period_meter
    import hall_meas_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_SIG,
    output logic [CNT_W-1:0] OUT_HALF,
    output logic             OUT_VALID,
    output logic             OUT_LEVEL,
    output logic             OUT_TIMEOUT
);

    logic             sync_lvl;
    logic             edge_det;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             valid_q, valid_d;
    logic             level_q, level_d;
    logic             tmo_q, tmo_d;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK   (CLK),
        .RST   (RST),
        .IN_SIG(IN_SIG),
        .level (sync_lvl),
        .E     (edge_det)
    );

`ifdef HALL_PERIOD_AVG_EN
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             have_q, have_d;
    logic [CNT_W:0]   sum;

    assign sum = {1'b0, prev_q} + {1'b0, cnt_q};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q <= '0;
            have_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            have_q <= have_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        valid_d = 1'b0;
        level_d = level_q;
        tmo_d   = tmo_q;
`ifdef HALL_PERIOD_AVG_EN
        prev_d  = prev_q;
        have_d  = have_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (edge_det) begin
                    state_d = ST_MEASURE;
                end
            end
            default: begin
                // An edge coinciding with the stall limit still reports
                if (edge_det) begin
                    cnt_d = '0;
`ifdef HALL_PERIOD_AVG_EN
                    prev_d = cnt_q;
                    have_d = 1'b1;
                    if (have_q) begin
                        half_d  = sum[CNT_W:1];
                        valid_d = 1'b1;
                        level_d = sync_lvl;
                        tmo_d   = 1'b0;
                    end
`else
                    half_d  = cnt_q;
                    valid_d = 1'b1;
                    level_d = sync_lvl;
                    tmo_d   = 1'b0;
`endif
                end else if (cnt_q == TIMEOUT - 16'd1) begin
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
`ifdef HALL_PERIOD_AVG_EN
                    have_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            valid_q <= 1'b0;
            level_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            valid_q <= valid_d;
            level_q <= level_d;
            tmo_q   <= tmo_d;
        end
    end

    assign OUT_HALF    = half_q;
    assign OUT_VALID   = valid_q;
    assign OUT_LEVEL   = level_q;
    assign OUT_TIMEOUT = tmo_q;

endmodule

// File: tb/tb_hall_period_meter.sv
// Scoreboard bench for hall_period_meter with a short stall limit.
// Stimulus queues expected results; a monitor checks each valid strobe.
module tb_hall_period_meter;

    localparam logic [15:0] TMO   = 16'd20;
    localparam int          TMO_I = 20;

    typedef struct {
        logic [15:0] half;
        logic        level;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_sig;
    logic [15:0] half;
    logic        valid;
    logic        level;
    logic        tmo;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        sig = 1'b0;
    bit          armed = 1'b0;
    bit          have_prev = 1'b0;
    logic [15:0] prev_raw = '0;
    logic [15:0] last_half = '0;

    always #5 clk = ~clk;

    hall_period_meter #(
        .SYNC_STAGES(2),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .IN_SIG     (in_sig),
        .OUT_HALF   (half),
        .OUT_VALID  (valid),
        .OUT_LEVEL  (level),
        .OUT_TIMEOUT(tmo)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input int raw, input logic lvl);
        exp_t e;
`ifdef HALL_PERIOD_AVG_EN
        logic [16:0] s;
        if (!have_prev) begin
            prev_raw  = 16'(raw);
            have_prev = 1'b1;
            return;
        end
        s        = {1'b0, prev_raw} + 17'(raw);
        prev_raw = 16'(raw);
        e.half   = s[16:1];
`else
        e.half = 16'(raw);
`endif
        e.level   = lvl;
        last_half = e.half;
        sb.push_back(e);
    endfunction

    // Toggle n cycles after the previous toggle; 'done' cycles already spent
    task automatic tog(input int n, input int done = 0);
        repeat (n - done) @(posedge clk);
        #1;
        sig    = ~sig;
        in_sig = sig;
        if (armed && n <= TMO_I) begin
            push(n - 1, sig);
        end else begin
            have_prev = 1'b0;
        end
        armed = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got half=%0d, expected no strobe",
                         half);
            end else begin
                e = sb.pop_front();
                check("half", int'(half), int'(e.half));
                check("level", int'(level), int'(e.level));
                check("timeout_clr", int'(tmo), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        in_sig = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 in_sig = ~in_sig;
        end
        @(negedge clk);
        check("rst_half", int'(half), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_level", int'(level), 0);
        check("rst_timeout", int'(tmo), 0);
        in_sig = 1'b0;
        sig    = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // first edge only arms, second reports
        tog(3);
        tog(7);

        repeat (6) tog(6);

        repeat (6) tog(sig ? 10 : 4);

        // stall
        tog(5);
        repeat (TMO_I + 2) @(posedge clk);
        @(negedge clk);
        check("tmo_before", int'(tmo), 0);
        @(posedge clk);
        @(negedge clk);
        check("tmo_rise", int'(tmo), 1);
        check("tmo_hold_half", int'(half), int'(last_half));
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("tmo_idle", int'(tmo), 1);
        tog(40);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("tmo_first_edge", int'(tmo), 1);
        tog(8, 5);
        repeat (3) tog(8);

        // edge coinciding with the stall limit, then fastest toggling
        tog(5);
        tog(TMO_I);
        repeat (6) tog(1);

        // reset mid-measurement
        tog(9);
        repeat (5) @(posedge clk);
        #1;
        rst       = 1'b1;
        sig       = 1'b0;
        in_sig    = 1'b0;
        armed     = 1'b0;
        have_prev = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_half", int'(half), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_timeout", int'(tmo), 0);
        check("mid_rst_pending", sb.size(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        tog(3);
        tog(12);
        tog(12);

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
